// File: rtl/rv32i_pkg.sv
// RV32I shared definitions: opcodes, funct3/funct7 constants and the decoded-control
// bundle handed from decode to execute.
package rv32i_pkg;

    localparam logic [6:0] OP       = 7'b0110011;
    localparam logic [6:0] OP_IMM   = 7'b0010011;
    localparam logic [6:0] LOAD     = 7'b0000011;
    localparam logic [6:0] STORE    = 7'b0100011;
    localparam logic [6:0] BRANCH   = 7'b1100011;
    localparam logic [6:0] JAL      = 7'b1101111;
    localparam logic [6:0] JALR     = 7'b1100111;
    localparam logic [6:0] LUI      = 7'b0110111;
    localparam logic [6:0] AUIPC    = 7'b0010111;
    localparam logic [6:0] SYSTEM   = 7'b1110011;
    localparam logic [6:0] MISC_MEM = 7'b0001111;

    localparam logic [2:0] F3_ADD_SUB = 3'b000;
    localparam logic [2:0] F3_SLL     = 3'b001;
    localparam logic [2:0] F3_SLT     = 3'b010;
    localparam logic [2:0] F3_SLTU    = 3'b011;
    localparam logic [2:0] F3_XOR     = 3'b100;
    localparam logic [2:0] F3_SR      = 3'b101;
    localparam logic [2:0] F3_OR      = 3'b110;
    localparam logic [2:0] F3_AND     = 3'b111;

    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    localparam logic [2:0] F3_BYTE  = 3'b000;
    localparam logic [2:0] F3_HALF  = 3'b001;
    localparam logic [2:0] F3_WORD  = 3'b010;
    localparam logic [2:0] F3_BYTEU = 3'b100;
    localparam logic [2:0] F3_HALFU = 3'b101;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    typedef struct packed {
        logic [4:0]  rs1_addr;
        logic [4:0]  rs2_addr;
        logic [4:0]  rd_addr;
        logic [31:0] immediate;
        logic [2:0]  alu_op;
        logic        alu_src_op;
        logic        i_sub;
        logic        i_unsigned;
        logic        i_arith;
        logic [3:0]  branch_op;
        logic        pc_src_op;
        logic        jalr_op;
        logic        alu_pc_op;
        logic        lui_op;
        logic        reg_write;
        logic        mem_read;
        logic        mem_write;
        logic [2:0]  mem_size;
    } ctrl_t;

    // Branches only need eq (000) or a signed/unsigned less-than (010/011) from the ALU.
    function automatic logic [2:0] branch_alu_op(input logic [2:0] funct3);
        case (funct3)
            F3_BLT, F3_BGE:   branch_alu_op = F3_SLT;
            F3_BLTU, F3_BGEU: branch_alu_op = F3_SLTU;
            default:          branch_alu_op = F3_ADD_SUB;
        endcase
    endfunction

endpackage

// File: rtl/decode_stage_imm_gen.sv
// Combinational RV32I immediate generator: picks the I/S/B/U/J format from the opcode
// and sign-extends; every other opcode (including R-type) yields zero.
module imm_gen
    import rv32i_pkg::*;
(
    input  logic [31:0] instr,
    output logic [31:0] imm
);

    always_comb begin
        imm = '0;
        case (instr[6:0])
            OP_IMM, LOAD, JALR:
                imm = {{20{instr[31]}}, instr[31:20]};
            STORE:
                imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
            BRANCH:
                imm = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
            LUI, AUIPC:
                imm = {instr[31:12], 12'h000};
            JAL:
                imm = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
            default:
                imm = '0;
        endcase
    end

endmodule

// File: rtl/decode_stage.sv
// RV32I decoder plus ID/EX pipeline register with stall and flush.
// Define DECODE_ILLEGAL_EN to add the o_illegal output for malformed encodings.
module decode_stage
    import rv32i_pkg::*;
#(
    parameter int unsigned      XLEN     = 32,
    parameter logic [XLEN-1:0]  RESET_PC = '0
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic [31:0]      i_instr,
    input  logic [XLEN-1:0]  i_pc,
    input  logic             i_stall,
    input  logic             i_flush,
    output logic             o_valid,
    output logic [XLEN-1:0]  o_pc,
    output logic [4:0]       o_rs1_addr,
    output logic [4:0]       o_rs2_addr,
    output logic [4:0]       o_rd_addr,
    output logic [XLEN-1:0]  o_immediate,
    output logic [2:0]       o_alu_op,
    output logic             o_alu_src_op,
    output logic             o_i_sub,
    output logic             o_i_unsigned,
    output logic             o_i_arith,
    output logic [3:0]       o_branch_op,
    output logic             o_pc_src_op,
    output logic             o_jalr_op,
    output logic             o_alu_pc_op,
    output logic             o_lui_op,
    output logic             o_reg_write,
    output logic             o_mem_read,
    output logic             o_mem_write,
`ifdef DECODE_ILLEGAL_EN
    output logic             o_illegal,
`endif
    output logic [2:0]       o_mem_size
);

    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [4:0]  rd, rs1, rs2;
    logic [31:0] imm;
    ctrl_t       dec;
    logic        dec_illegal;

    ctrl_t       ctrl_q;
    logic        valid_q;
    logic [XLEN-1:0] pc_q;
    logic        accept;

    assign opcode = i_instr[6:0];
    assign rd     = i_instr[11:7];
    assign funct3 = i_instr[14:12];
    assign rs1    = i_instr[19:15];
    assign rs2    = i_instr[24:20];
    assign funct7 = i_instr[31:25];

    imm_gen u_imm_gen (
        .instr (i_instr),
        .imm   (imm)
    );

    always_comb begin
        dec         = '0;
        dec_illegal = 1'b0;
        dec.immediate = imm;
        case (opcode)
            OP: begin
                dec.rs1_addr   = rs1;
                dec.rs2_addr   = rs2;
                dec.rd_addr    = rd;
                dec.alu_op     = funct3;
                dec.i_sub      = funct7[5] && (funct3 == F3_ADD_SUB);
                dec.i_arith    = funct7[5] && (funct3 == F3_SR);
                dec.i_unsigned = (funct3 == F3_SLTU);
                dec.reg_write  = (rd != 5'd0);
                dec_illegal    = !((funct7 == F7_BASE) ||
                                   ((funct7 == F7_ALT) && ((funct3 == F3_ADD_SUB) || (funct3 == F3_SR))));
            end
            OP_IMM: begin
                dec.rs1_addr   = rs1;
                dec.rd_addr    = rd;
                dec.alu_op     = funct3;
                dec.alu_src_op = 1'b1;
                dec.i_unsigned = (funct3 == F3_SLTU);
                dec.i_arith    = (funct3 == F3_SR) && funct7[5];
                dec.reg_write  = (rd != 5'd0);
                // Only shift-immediates constrain the upper immediate bits.
                dec_illegal    = ((funct3 == F3_SLL) && (funct7 != F7_BASE)) ||
                                 ((funct3 == F3_SR) && (funct7 != F7_BASE) && (funct7 != F7_ALT));
            end
            LOAD: begin
                dec.rs1_addr   = rs1;
                dec.rd_addr    = rd;
                dec.alu_src_op = 1'b1;
                dec.mem_read   = 1'b1;
                dec.mem_size   = funct3;
                dec.reg_write  = (rd != 5'd0);
                dec_illegal    = (funct3 == 3'b011) || (funct3[2:1] == 2'b11);
            end
            STORE: begin
                dec.rs1_addr   = rs1;
                dec.rs2_addr   = rs2;
                dec.alu_src_op = 1'b1;
                dec.mem_write  = 1'b1;
                dec.mem_size   = funct3;
                dec_illegal    = funct3[2] || (funct3 == 3'b011);
            end
            BRANCH: begin
                dec.rs1_addr   = rs1;
                dec.rs2_addr   = rs2;
                dec.alu_op     = branch_alu_op(funct3);
                dec.i_sub      = 1'b1;
                dec.i_unsigned = (funct3 == F3_BLTU) || (funct3 == F3_BGEU);
                dec.branch_op  = {1'b1, funct3};
                dec.pc_src_op  = 1'b1;
                dec_illegal    = (funct3[2:1] == 2'b01);
            end
            JAL: begin
                dec.rd_addr    = rd;
                dec.alu_src_op = 1'b1;
                dec.pc_src_op  = 1'b1;
                dec.reg_write  = (rd != 5'd0);
            end
            JALR: begin
                dec.rs1_addr   = rs1;
                dec.rd_addr    = rd;
                dec.alu_src_op = 1'b1;
                dec.pc_src_op  = 1'b1;
                dec.jalr_op    = 1'b1;
                dec.reg_write  = (rd != 5'd0);
                dec_illegal    = (funct3 != 3'b000);
            end
            LUI: begin
                dec.rd_addr    = rd;
                dec.alu_src_op = 1'b1;
                dec.lui_op     = 1'b1;
                dec.reg_write  = (rd != 5'd0);
            end
            AUIPC: begin
                dec.rd_addr    = rd;
                dec.alu_src_op = 1'b1;
                dec.alu_pc_op  = 1'b1;
                dec.reg_write  = (rd != 5'd0);
            end
            SYSTEM, MISC_MEM: begin
                dec.immediate  = '0;
            end
            default: begin
                dec_illegal    = 1'b1;
            end
        endcase
        // Malformed encodings travel down the pipe as a NOP.
        if (dec_illegal) begin
            dec = '0;
        end
    end

    assign o_ready = !valid_q || !i_stall;
    assign accept  = i_valid && o_ready && !i_flush;

`ifdef DECODE_ILLEGAL_EN
    logic illegal_q;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            illegal_q <= 1'b0;
        end else if (!i_flush && accept) begin
            illegal_q <= dec_illegal;
        end
    end

    assign o_illegal = illegal_q;
`endif

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            valid_q <= 1'b0;
            pc_q    <= RESET_PC;
            ctrl_q  <= '0;
        end else if (i_flush) begin
            valid_q <= 1'b0;
        end else if (accept) begin
            valid_q <= 1'b1;
            pc_q    <= i_pc;
            ctrl_q  <= dec;
        end else if (!i_stall) begin
            valid_q <= 1'b0;
        end
    end

    assign o_valid      = valid_q;
    assign o_pc         = pc_q;
    assign o_rs1_addr   = ctrl_q.rs1_addr;
    assign o_rs2_addr   = ctrl_q.rs2_addr;
    assign o_rd_addr    = ctrl_q.rd_addr;
    assign o_immediate  = ctrl_q.immediate;
    assign o_alu_op     = ctrl_q.alu_op;
    assign o_alu_src_op = ctrl_q.alu_src_op;
    assign o_i_sub      = ctrl_q.i_sub;
    assign o_i_unsigned = ctrl_q.i_unsigned;
    assign o_i_arith    = ctrl_q.i_arith;
    assign o_branch_op  = ctrl_q.branch_op;
    assign o_pc_src_op  = ctrl_q.pc_src_op;
    assign o_jalr_op    = ctrl_q.jalr_op;
    assign o_alu_pc_op  = ctrl_q.alu_pc_op;
    assign o_lui_op     = ctrl_q.lui_op;
    assign o_reg_write  = ctrl_q.reg_write;
    assign o_mem_read   = ctrl_q.mem_read;
    assign o_mem_write  = ctrl_q.mem_write;
    assign o_mem_size   = ctrl_q.mem_size;

endmodule

// File: tb/tb_decode_stage.sv
// Directed self-checking bench for decode_stage; hand-encoded RV32I vectors.
module tb_decode_stage;

    logic        i_clk = 1'b0;
    logic        i_rst;
    logic        i_valid;
    logic        o_ready;
    logic [31:0] i_instr;
    logic [31:0] i_pc;
    logic        i_stall;
    logic        i_flush;
    logic        o_valid;
    logic [31:0] o_pc;
    logic [4:0]  o_rs1_addr, o_rs2_addr, o_rd_addr;
    logic [31:0] o_immediate;
    logic [2:0]  o_alu_op;
    logic        o_alu_src_op, o_i_sub, o_i_unsigned, o_i_arith;
    logic [3:0]  o_branch_op;
    logic        o_pc_src_op, o_jalr_op, o_alu_pc_op, o_lui_op;
    logic        o_reg_write, o_mem_read, o_mem_write;
    logic [2:0]  o_mem_size;
`ifdef DECODE_ILLEGAL_EN
    logic        o_illegal;
`endif

    int checks = 0;
    int errors = 0;

    localparam logic [31:0] RST_PC  = 32'h0000_0100;
    localparam logic [31:0] ADDI_I  = 32'h0050_0093;
    localparam logic [31:0] SUB_I   = 32'h4020_81B3;
    localparam logic [31:0] BLTU_I  = 32'h0020_E463;
    localparam logic [31:0] LUI_I   = 32'h1234_52B7;
    localparam logic [31:0] SRAI_I  = 32'h4030_D213;
    localparam logic [31:0] SW_I    = 32'h0020_A223;
    localparam logic [31:0] JAL_I   = 32'hFFDF_F0EF;
    localparam logic [31:0] ECALL_I = 32'h0000_0073;
    localparam logic [31:0] BAD_I   = 32'hFFFF_FFFF;

    decode_stage #(.XLEN(32), .RESET_PC(RST_PC)) dut (
        .i_clk        (i_clk),
        .i_rst        (i_rst),
        .i_valid      (i_valid),
        .o_ready      (o_ready),
        .i_instr      (i_instr),
        .i_pc         (i_pc),
        .i_stall      (i_stall),
        .i_flush      (i_flush),
        .o_valid      (o_valid),
        .o_pc         (o_pc),
        .o_rs1_addr   (o_rs1_addr),
        .o_rs2_addr   (o_rs2_addr),
        .o_rd_addr    (o_rd_addr),
        .o_immediate  (o_immediate),
        .o_alu_op     (o_alu_op),
        .o_alu_src_op (o_alu_src_op),
        .o_i_sub      (o_i_sub),
        .o_i_unsigned (o_i_unsigned),
        .o_i_arith    (o_i_arith),
        .o_branch_op  (o_branch_op),
        .o_pc_src_op  (o_pc_src_op),
        .o_jalr_op    (o_jalr_op),
        .o_alu_pc_op  (o_alu_pc_op),
        .o_lui_op     (o_lui_op),
        .o_reg_write  (o_reg_write),
        .o_mem_read   (o_mem_read),
        .o_mem_write  (o_mem_write),
`ifdef DECODE_ILLEGAL_EN
        .o_illegal    (o_illegal),
`endif
        .o_mem_size   (o_mem_size)
    );

    always #5 i_clk = ~i_clk;

    task automatic cycle();
        @(posedge i_clk);
        #1;
    endtask

    task automatic drive(input logic [31:0] instr, input logic [31:0] pc);
        i_valid = 1'b1;
        i_instr = instr;
        i_pc    = pc;
    endtask

    task automatic test_reset();
        i_rst = 1'b1;
        cycle();
        cycle();
        checks++;
        if ({o_valid, o_ready} !== 2'b01) begin
            errors++; $display("FAIL reset_valid_ready: got %b expected 01", {o_valid, o_ready});
        end
        checks++;
        if (o_pc !== RST_PC) begin
            errors++; $display("FAIL reset_pc: got %h expected %h", o_pc, RST_PC);
        end
        checks++;
        if ({o_rd_addr, o_immediate, o_reg_write, o_alu_src_op, o_mem_write} !== 40'd0) begin
            errors++; $display("FAIL reset_ctrl: got %h expected 0",
                               {o_rd_addr, o_immediate, o_reg_write, o_alu_src_op, o_mem_write});
        end
        i_rst = 1'b0;
    endtask

    task automatic test_addi();
        drive(ADDI_I, 32'h200);
        cycle();
        i_valid = 1'b0;
        checks++;
        if ({o_valid, o_alu_src_op, o_reg_write, o_rd_addr, o_rs1_addr, o_alu_op} !== {3'b111, 5'd1, 5'd0, 3'b000}) begin
            errors++; $display("FAIL addi_ctrl: got v=%b src=%b rw=%b rd=%0d rs1=%0d op=%b expected 1 1 1 1 0 000",
                               o_valid, o_alu_src_op, o_reg_write, o_rd_addr, o_rs1_addr, o_alu_op);
        end
        checks++;
        if ({o_immediate, o_pc} !== {32'd5, 32'h200}) begin
            errors++; $display("FAIL addi_imm_pc: got imm=%h pc=%h expected 00000005 00000200", o_immediate, o_pc);
        end
`ifdef DECODE_ILLEGAL_EN
        checks++;
        if (o_illegal !== 1'b0) begin
            errors++; $display("FAIL addi_illegal: got %b expected 0", o_illegal);
        end
`endif
    endtask

    task automatic test_sub();
        drive(SUB_I, 32'h204);
        cycle();
        i_valid = 1'b0;
        checks++;
        if ({o_i_sub, o_alu_src_op, o_alu_op, o_rs1_addr, o_rs2_addr, o_rd_addr} !== {2'b10, 3'b000, 5'd1, 5'd2, 5'd3}) begin
            errors++; $display("FAIL sub_ctrl: got sub=%b src=%b op=%b rs1=%0d rs2=%0d rd=%0d expected 1 0 000 1 2 3",
                               o_i_sub, o_alu_src_op, o_alu_op, o_rs1_addr, o_rs2_addr, o_rd_addr);
        end
        checks++;
        if ({o_immediate, o_i_arith, o_reg_write} !== {32'd0, 1'b0, 1'b1}) begin
            errors++; $display("FAIL sub_imm: got imm=%h arith=%b rw=%b expected 0 0 1", o_immediate, o_i_arith, o_reg_write);
        end
    endtask

    task automatic test_branch();
        drive(BLTU_I, 32'h208);
        cycle();
        i_valid = 1'b0;
        checks++;
        if ({o_branch_op, o_pc_src_op, o_i_sub, o_i_unsigned, o_reg_write, o_alu_op} !== {4'b1110, 4'b1110, 3'b011}) begin
            errors++; $display("FAIL bltu_ctrl: got br=%b pcs=%b sub=%b uns=%b rw=%b op=%b expected 1110 1 1 1 0 011",
                               o_branch_op, o_pc_src_op, o_i_sub, o_i_unsigned, o_reg_write, o_alu_op);
        end
        checks++;
        if ({o_immediate, o_rs1_addr, o_rs2_addr, o_rd_addr} !== {32'd8, 5'd1, 5'd2, 5'd0}) begin
            errors++; $display("FAIL bltu_fields: got imm=%h rs1=%0d rs2=%0d rd=%0d expected 8 1 2 0",
                               o_immediate, o_rs1_addr, o_rs2_addr, o_rd_addr);
        end
    endtask

    task automatic test_lui();
        drive(LUI_I, 32'h20C);
        cycle();
        i_valid = 1'b0;
        checks++;
        if ({o_lui_op, o_alu_src_op, o_reg_write, o_rd_addr, o_alu_pc_op} !== {3'b111, 5'd5, 1'b0}) begin
            errors++; $display("FAIL lui_ctrl: got lui=%b src=%b rw=%b rd=%0d auipc=%b expected 1 1 1 5 0",
                               o_lui_op, o_alu_src_op, o_reg_write, o_rd_addr, o_alu_pc_op);
        end
        checks++;
        if (o_immediate !== 32'h1234_5000) begin
            errors++; $display("FAIL lui_imm: got %h expected 12345000", o_immediate);
        end
    endtask

    task automatic test_misc_formats();
        drive(SRAI_I, 32'h210);
        cycle();
        checks++;
        if ({o_i_arith, o_i_sub, o_alu_op, o_immediate, o_rd_addr} !== {2'b10, 3'b101, 32'h403, 5'd4}) begin
            errors++; $display("FAIL srai: got arith=%b sub=%b op=%b imm=%h rd=%0d expected 1 0 101 403 4",
                               o_i_arith, o_i_sub, o_alu_op, o_immediate, o_rd_addr);
        end
        drive(SW_I, 32'h214);
        cycle();
        checks++;
        if ({o_mem_write, o_mem_read, o_mem_size, o_reg_write, o_alu_src_op, o_immediate, o_rd_addr}
            !== {2'b10, 3'b010, 2'b01, 32'd4, 5'd0}) begin
            errors++; $display("FAIL sw: got mw=%b mr=%b sz=%b rw=%b src=%b imm=%h rd=%0d expected 1 0 010 0 1 4 0",
                               o_mem_write, o_mem_read, o_mem_size, o_reg_write, o_alu_src_op, o_immediate, o_rd_addr);
        end
        drive(JAL_I, 32'h218);
        cycle();
        checks++;
        if ({o_pc_src_op, o_reg_write, o_rd_addr, o_alu_src_op, o_jalr_op, o_immediate}
            !== {2'b11, 5'd1, 2'b10, 32'hFFFF_FFFC}) begin
            errors++; $display("FAIL jal: got pcs=%b rw=%b rd=%0d src=%b jalr=%b imm=%h expected 1 1 1 1 0 fffffffc",
                               o_pc_src_op, o_reg_write, o_rd_addr, o_alu_src_op, o_jalr_op, o_immediate);
        end
        drive(ECALL_I, 32'h21C);
        cycle();
        i_valid = 1'b0;
        checks++;
        if ({o_valid, o_reg_write, o_alu_src_op, o_pc_src_op, o_immediate} !== {1'b1, 3'b000, 32'd0}) begin
            errors++; $display("FAIL ecall_nop: got v=%b rw=%b src=%b pcs=%b imm=%h expected 1 0 0 0 0",
                               o_valid, o_reg_write, o_alu_src_op, o_pc_src_op, o_immediate);
        end
    endtask

    task automatic test_illegal();
        drive(BAD_I, 32'h220);
        cycle();
        i_valid = 1'b0;
        checks++;
        if ({o_valid, o_reg_write, o_mem_write, o_mem_read, o_rd_addr, o_immediate} !== {1'b1, 3'b000, 5'd0, 32'd0}) begin
            errors++; $display("FAIL bad_opcode_nop: got v=%b rw=%b mw=%b mr=%b rd=%0d imm=%h expected 1 0 0 0 0 0",
                               o_valid, o_reg_write, o_mem_write, o_mem_read, o_rd_addr, o_immediate);
        end
`ifdef DECODE_ILLEGAL_EN
        checks++;
        if (o_illegal !== 1'b1) begin
            errors++; $display("FAIL bad_opcode_illegal: got %b expected 1", o_illegal);
        end
`endif
    endtask

    task automatic test_stall();
        drive(ADDI_I, 32'h300);
        cycle();
        i_stall = 1'b1;
        drive(SUB_I, 32'h304);
        #1;
        checks++;
        if (o_ready !== 1'b0) begin
            errors++; $display("FAIL stall_ready: got %b expected 0", o_ready);
        end
        for (int i = 0; i < 3; i++) begin
            cycle();
            checks++;
            if ({o_valid, o_pc, o_rd_addr, o_immediate, o_i_sub} !== {1'b1, 32'h300, 5'd1, 32'd5, 1'b0}) begin
                errors++; $display("FAIL stall_hold_%0d: got v=%b pc=%h rd=%0d imm=%h sub=%b expected 1 300 1 5 0",
                                   i, o_valid, o_pc, o_rd_addr, o_immediate, o_i_sub);
            end
        end
        i_stall = 1'b0;
        #1;
        checks++;
        if (o_ready !== 1'b1) begin
            errors++; $display("FAIL unstall_ready: got %b expected 1", o_ready);
        end
        cycle();
        i_valid = 1'b0;
        checks++;
        if ({o_valid, o_pc, o_rd_addr, o_i_sub} !== {1'b1, 32'h304, 5'd3, 1'b1}) begin
            errors++; $display("FAIL unstall_load: got v=%b pc=%h rd=%0d sub=%b expected 1 304 3 1",
                               o_valid, o_pc, o_rd_addr, o_i_sub);
        end
    endtask

    task automatic test_back_to_back();
        drive(ADDI_I, 32'h400);
        cycle();
        checks++;
        if ({o_valid, o_pc, o_rd_addr} !== {1'b1, 32'h400, 5'd1}) begin
            errors++; $display("FAIL b2b_first: got v=%b pc=%h rd=%0d expected 1 400 1", o_valid, o_pc, o_rd_addr);
        end
        drive(LUI_I, 32'h404);
        cycle();
        i_valid = 1'b0;
        checks++;
        if ({o_valid, o_pc, o_rd_addr, o_lui_op} !== {1'b1, 32'h404, 5'd5, 1'b1}) begin
            errors++; $display("FAIL b2b_second: got v=%b pc=%h rd=%0d lui=%b expected 1 404 5 1",
                               o_valid, o_pc, o_rd_addr, o_lui_op);
        end
        cycle();
        checks++;
        if ({o_valid, o_ready} !== 2'b01) begin
            errors++; $display("FAIL drain: got v/ready=%b expected 01", {o_valid, o_ready});
        end
    endtask

    task automatic test_flush();
        drive(ADDI_I, 32'h500);
        cycle();
        i_flush = 1'b1;
        i_stall = 1'b1;
        drive(LUI_I, 32'h504);
        #1;
        checks++;
        if (o_ready !== 1'b0) begin
            errors++; $display("FAIL flush_ready: got %b expected 0", o_ready);
        end
        cycle();
        checks++;
        if (o_valid !== 1'b0) begin
            errors++; $display("FAIL flush_valid: got %b expected 0", o_valid);
        end
        i_flush = 1'b0;
        i_stall = 1'b0;
        i_valid = 1'b0;
        cycle();
        checks++;
        if (o_valid !== 1'b0) begin
            errors++; $display("FAIL flush_dropped: got %b expected 0", o_valid);
        end
    endtask

    task automatic test_reset_mid_hold();
        drive(LUI_I, 32'h600);
        cycle();
        i_stall = 1'b1;
        drive(ADDI_I, 32'h604);
        cycle();
        i_rst = 1'b1;
        cycle();
        checks++;
        if ({o_valid, o_pc} !== {1'b0, RST_PC}) begin
            errors++; $display("FAIL rst_hold_valid_pc: got v=%b pc=%h expected 0 %h", o_valid, o_pc, RST_PC);
        end
        checks++;
        if ({o_rd_addr, o_immediate, o_lui_op, o_reg_write, o_alu_src_op} !== 40'd0) begin
            errors++; $display("FAIL rst_hold_ctrl: got rd=%0d imm=%h lui=%b rw=%b src=%b expected all 0",
                               o_rd_addr, o_immediate, o_lui_op, o_reg_write, o_alu_src_op);
        end
        i_rst   = 1'b0;
        i_stall = 1'b0;
        i_valid = 1'b0;
        cycle();
    endtask

    initial begin
        i_rst   = 1'b1;
        i_valid = 1'b0;
        i_instr = '0;
        i_pc    = '0;
        i_stall = 1'b0;
        i_flush = 1'b0;
        test_reset();
        test_addi();
        test_sub();
        test_branch();
        test_lui();
        test_misc_formats();
        test_illegal();
        test_stall();
        test_back_to_back();
        test_flush();
        test_reset_mid_hold();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
